// File: rtl/ifetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package ifetch_queue_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          ENTRY_W          = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/ifetch_queue_fifo.sv
// Synchronous FIFO holding {pc, instr} entries; flush empties it in one edge.
module fetchq_fifo
    import ifetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [ENTRY_W-1:0]       wdata,
    output logic [ENTRY_W-1:0]       rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               do_push;
    logic               do_pop;

    // A pop frees the slot that a simultaneous push into a full FIFO needs.
    assign do_pop  = pop & (count != '0);
    assign do_push = push & ((count != CW'(DEPTH)) | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch front end: owns the fetch PC, runs the imem req/ack handshake and
// queues tagged instructions for the IF/ID stage.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] instr_pcplus4,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e       state, state_nxt;
    logic [31:0]        fetch_pc, fetch_pc_nxt;
    logic [31:0]        addr_nxt;
    logic [31:0]        redirect_word;
    logic               push, pop, flush;
    logic [CW-1:0]      count;
    logic [CW:0]        count_after;
    logic               space_ok;
    logic [ENTRY_W-1:0] head;

    always_comb begin
        redirect_word = {redirect_pc[31:2], 2'b00};
        pop           = instr_ready & (count != '0) & ~redirect;
        push          = (state == ST_REQ) & imem_ack & ~redirect;
        flush         = redirect;
        // Issue only when the slot for the returning word is guaranteed.
        count_after   = redirect ? '0
                      : {1'b0, count} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
        space_ok      = count_after < (CW + 1)'(DEPTH);

        state_nxt     = state;
        fetch_pc_nxt  = fetch_pc;
        addr_nxt      = imem_addr;

        case (state)
            ST_IDLE: begin
                if (redirect) begin
                    fetch_pc_nxt = redirect_word;
                    addr_nxt     = redirect_word;
                    state_nxt    = ST_REQ;
                end else if (space_ok) begin
                    addr_nxt  = fetch_pc;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redirect) begin
                    fetch_pc_nxt = redirect_word;
                    if (imem_ack) begin
                        addr_nxt = redirect_word;
                    end else begin
                        state_nxt = ST_DROP;
                    end
                end else if (imem_ack) begin
                    fetch_pc_nxt = fetch_pc + 32'd4;
                    if (space_ok) begin
                        addr_nxt = fetch_pc + 32'd4;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (redirect) begin
                    fetch_pc_nxt = redirect_word;
                    if (imem_ack) begin
                        addr_nxt  = redirect_word;
                        state_nxt = ST_REQ;
                    end
                end else if (imem_ack) begin
                    addr_nxt  = fetch_pc;
                    state_nxt = ST_REQ;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= 32'd0;
        end else begin
            state     <= state_nxt;
            fetch_pc  <= fetch_pc_nxt;
            imem_req  <= (state_nxt != ST_IDLE);
            imem_addr <= addr_nxt;
        end
    end

    fetchq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata ({imem_addr, imem_rdata}),
        .rdata (head),
        .count (count)
    );

    assign instr_valid   = (count != '0);
    assign instr         = head[31:0];
    assign instr_pc      = head[63:32];
    assign instr_pcplus4 = head[63:32] + 32'd4;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: scripted scenarios plus random traffic against a
// queue-based reference model of the fetch front end.
module tb_ifetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pcplus4;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    int checks = 0;
    int errors = 0;

    // Reference model: outstanding request (addr, discard flag), fetch PC, queue.
    logic        m_out;
    logic        m_drop;
    logic [31:0] m_addr;
    logic [31:0] m_pc;
    logic [63:0] m_q[$];

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_pcplus4 (instr_pcplus4),
        .instr_ready   (instr_ready),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_A5A5;
    endfunction

    task automatic model_reset();
        m_out  = 1'b0;
        m_drop = 1'b0;
        m_addr = 32'd0;
        m_pc   = 32'd0;
        m_q.delete();
    endtask

    task automatic model_edge(input logic ack, input logic ready, input logic redir,
                              input logic [31:0] rpc);
        logic [63:0] dummy;
        if (redir) begin
            m_q.delete();
            m_pc = {rpc[31:2], 2'b00};
            if (m_out && !ack) begin
                m_drop = 1'b1;
            end else begin
                m_out  = 1'b1;
                m_drop = 1'b0;
                m_addr = m_pc;
            end
        end else begin
            if (ready && m_q.size() != 0) dummy = m_q.pop_front();
            if (m_out && ack) begin
                if (!m_drop) begin
                    m_q.push_back({m_addr, mem_word(m_addr)});
                    m_pc = m_pc + 32'd4;
                end
                m_out  = 1'b0;
                m_drop = 1'b0;
            end
            if (!m_out && m_q.size() < DEPTH) begin
                m_out  = 1'b1;
                m_addr = m_pc;
            end
        end
    endtask

    function automatic logic [129:0] exp_vec();
        logic [63:0] h;
        logic        v;
        v = (m_q.size() != 0);
        h = v ? m_q[0] : 64'd0;
        return {m_out, m_addr, v, v ? {h[31:0], h[63:32], h[63:32] + 32'd4} : 96'd0};
    endfunction

    function automatic logic [129:0] dut_vec();
        return {imem_req, imem_addr, instr_valid,
                instr_valid ? {instr, instr_pc, instr_pcplus4} : 96'd0};
    endfunction

    // Drive inputs at the falling edge, advance DUT and model, return at next falling edge.
    task automatic step(input logic ack, input logic ready, input logic redir,
                        input logic [31:0] rpc);
        imem_ack    = ack;
        instr_ready = ready;
        redirect    = redir;
        redirect_pc = rpc;
        imem_rdata  = m_out ? mem_word(m_addr) : $urandom();
        @(posedge clk);
        model_edge(ack, ready, redir, rpc);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        imem_rdata  = 32'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        imem_ack = 1'b0; instr_ready = 1'b0; redirect = 1'b0;
        redirect_pc = 32'd0; imem_rdata = 32'd0;
        #3;
        checks++;
        if ({imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pcplus4} !==
            {1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd4}) begin
            errors++;
            $display("FAIL reset_values: got req=%b addr=%h valid=%b instr=%h pc=%h pc4=%h want 0/0/0/0/0/4",
                     imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pcplus4);
        end
        do_reset();
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset_release: dut=%h model=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'd0);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * (k - 1)) ||
                instr_valid !== (k >= 2) ||
                (k >= 2 && instr_pc !== 32'(4 * (k - 2))) ||
                (k == 2 && instr !== 32'hA5A5_A5A5)) begin
                errors++;
                $display("FAIL stream_cycle%0d: req=%b addr=%h valid=%b pc=%h instr=%h, want addr=%h",
                         k, imem_req, imem_addr, instr_valid, instr_pc, instr, 32'(4 * (k - 1)));
            end
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stream_model%0d: dut=%h model=%h", k, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, 1'b0, 32'd0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL full_fill%0d: dut=%h model=%h", k, dut_vec(), exp_vec());
            end
        end
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 32'hC || instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL full_stall: req=%b addr=%h valid=%b pc=%h want 0/0000000c/1/00000000",
                     imem_req, imem_addr, instr_valid, instr_pc);
        end
        step(1'b0, 1'b1, 1'b0, 32'd0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h10 || instr_pc !== 32'h4) begin
            errors++;
            $display("FAIL full_pop_issue: req=%b addr=%h pc=%h want 1/00000010/00000004",
                     imem_req, imem_addr, instr_pc);
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'd0);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL full_pushpop%0d: dut=%h model=%h", k, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b1, 32'h100);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_hold_addr: req=%b addr=%h valid=%b want 1/00000000/0",
                     imem_req, imem_addr, instr_valid);
        end
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_drop_ack: req=%b addr=%h valid=%b want 1/00000100/0",
                     imem_req, imem_addr, instr_valid);
        end
        step(1'b1, 1'b0, 1'b0, 32'd0);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== (32'h100 ^ 32'hA5A5_A5A5)) begin
            errors++;
            $display("FAIL wait_first_valid: valid=%b pc=%h instr=%h want pc 00000100",
                     instr_valid, instr_pc, instr);
        end
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL wait_model: dut=%h model=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_redirect_ack();
        do_reset();
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1, 1'b0, 32'd0);
        checks++;
        if (imem_addr !== 32'h10) begin
            errors++;
            $display("FAIL redir_ack_setup: addr=%h want 00000010", imem_addr);
        end
        step(1'b1, 1'b1, 1'b1, 32'h203);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_ack_flush: req=%b addr=%h valid=%b want 1/00000200/0",
                     imem_req, imem_addr, instr_valid);
        end
        step(1'b1, 1'b0, 1'b0, 32'd0);
        checks++;
        if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr_pcplus4 !== 32'h204) begin
            errors++;
            $display("FAIL redir_ack_head: valid=%b pc=%h pc4=%h want 1/00000200/00000204",
                     instr_valid, instr_pc, instr_pcplus4);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        checks++;
        if (imem_addr !== 32'h0 || instr_pc !== 32'hFFFF_FFFC || instr_pcplus4 !== 32'h0) begin
            errors++;
            $display("FAIL wrap: addr=%h pc=%h pc4=%h want 00000000/fffffffc/00000000",
                     imem_addr, instr_pc, instr_pcplus4);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 32'd0);
        imem_ack = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pcplus4} !==
            {1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd4}) begin
            errors++;
            $display("FAIL async_reset: req=%b addr=%h valid=%b instr=%h pc=%h pc4=%h",
                     imem_req, imem_addr, instr_valid, instr, instr_pc, instr_pcplus4);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        step(1'b1, 1'b0, 1'b0, 32'd0);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL stale_ack: req=%b addr=%h valid=%b want 1/00000000/0",
                     imem_req, imem_addr, instr_valid);
        end
        step(1'b1, 1'b0, 1'b0, 32'd0);
        checks++;
        if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL resume_model: dut=%h model=%h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        logic        ack, rdy, rd;
        logic [31:0] rpc;
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            ack = ($urandom_range(0, 2) != 0);
            rdy = ($urandom_range(0, 1) != 0);
            rd  = ($urandom_range(0, 15) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : $urandom();
            step(ack, rdy, rd, rpc);
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random%0d: dut=%h model=%h", k, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_full();
        test_redirect_wait();
        test_redirect_ack();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
